and_or_sequencer: RTL and testbench

- Initiator side of the base AND/OR unit's command interface.
- Accepts operand/opcode requests on a valid/ready channel and drives aIn/bIn/doAnd/doOr to the unit for a programmable settle time.
- Samples out/isAnd, checks them against a locally computed expected result, and returns data plus an error flag on a valid/ready response channel.
- Sits between a test/control master and one base AND/OR unit instance.

---
 rtl/and_or_sequencer_if.sv | 25 ++
 rtl/and_or_sequencer.sv | 110 +++++++++++
 tb/tb_and_or_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/and_or_sequencer_if.sv
`timescale 1ns/1ps
// Request/response channels between a control master and the AND/OR sequencer.
interface and_or_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             reqValid;
  logic             reqReady;
  logic [WIDTH-1:0] reqA;
  logic [WIDTH-1:0] reqB;
  logic             reqOp;
  logic             rspValid;
  logic             rspReady;
  logic [WIDTH-1:0] rspData;
  logic             rspErr;

  modport master (
    output reqValid, reqA, reqB, reqOp, rspReady,
    input  reqReady, rspValid, rspData, rspErr
  );

  modport slave (
    input  reqValid, reqA, reqB, reqOp, rspReady,
    output reqReady, rspValid, rspData, rspErr
  );
endinterface

// File: rtl/and_or_sequencer.sv
`timescale 1ns/1ps
// Drives one AND/OR unit per request, holds the operands for a settle
// window, then checks the unit's answer and returns it with an error flag.
module and_or_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  and_or_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]     aIn,
  output logic [WIDTH-1:0]     bIn,
  output logic                 doAnd,
  output logic                 doOr,
  input  logic                 isAnd,
  input  logic [WIDTH-1:0]     out,
  output logic [CNT_WIDTH-1:0] opCount
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e               state_q;
  logic [SW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 op_q;
  logic [WIDTH-1:0]     aIn_q;
  logic [WIDTH-1:0]     bIn_q;
  logic                 doAnd_q;
  logic                 doOr_q;
  logic                 rspValid_q;
  logic [WIDTH-1:0]     rspData_q;
  logic                 rspErr_q;
  logic [CNT_WIDTH-1:0] opCount_q;
  logic [WIDTH-1:0]     exp_d;
  logic                 err_d;

  assign exp_d = op_q ? (a_q & b_q) : (a_q | b_q);
  // Case inequality so an X/Z from the unit is flagged as an error.
  assign err_d = (isAnd !== op_q) || (out !== exp_d);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      aIn_q      <= '0;
      bIn_q      <= '0;
      doAnd_q    <= 1'b0;
      doOr_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
      opCount_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.reqValid) begin
            a_q     <= bus.reqA;
            b_q     <= bus.reqB;
            op_q    <= bus.reqOp;
            aIn_q   <= bus.reqA;
            bIn_q   <= bus.reqB;
            doAnd_q <= bus.reqOp;
            doOr_q  <= !bus.reqOp;
            cnt_q   <= SETTLE_LOAD;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt_q == '0) begin
            rspData_q  <= out;
            rspErr_q   <= err_d;
            rspValid_q <= 1'b1;
            aIn_q      <= '0;
            bIn_q      <= '0;
            doAnd_q    <= 1'b0;
            doOr_q     <= 1'b0;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - SW'(1);
          end
        end
        RESP: begin
          if (bus.rspReady) begin
            rspValid_q <= 1'b0;
            opCount_q  <= opCount_q + CNT_WIDTH'(1);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reqReady = (state_q == IDLE);
  assign bus.rspValid = rspValid_q;
  assign bus.rspData  = rspData_q;
  assign bus.rspErr   = rspErr_q;
  assign aIn          = aIn_q;
  assign bIn          = bIn_q;
  assign doAnd        = doAnd_q;
  assign doOr         = doOr_q;
  assign opCount      = opCount_q;
endmodule

// File: tb/tb_and_or_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for and_or_sequencer driving a behavioural AND/OR unit
// stub with injectable faults.
module tb_and_or_sequencer;
  localparam int W  = 4;
  localparam int S  = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  and_or_sequencer_if #(.WIDTH(W)) bus ();

  logic [W-1:0]  aIn, bIn, out;
  logic          doAnd, doOr, isAnd;
  logic [CW-1:0] opCount;
  logic          f_isand, f_out;

  assign isAnd = f_isand ? 1'b0 : doAnd;
  assign out   = f_out ? '0 :
                 doAnd ? (aIn & bIn) :
                 doOr  ? (aIn | bIn) : '0;

  and_or_sequencer #(
    .WIDTH(W), .SETTLE_CYCLES(S), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstN(rstN), .bus(bus),
    .aIn(aIn), .bIn(bIn), .doAnd(doAnd), .doOr(doOr),
    .isAnd(isAnd), .out(out), .opCount(opCount)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Expected reply derived from what the stub unit will present.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op, input bit fi, input bit fo);
    exp_t e;
    logic [W-1:0] ideal;
    logic gi;
    ideal = op ? (a & b) : (a | b);
    e.a = a;
    e.b = b;
    e.op = op;
    e.d = fo ? '0 : ideal;
    gi = fi ? 1'b0 : op;
    e.e = (gi != op) || (e.d != ideal);
    return e;
  endfunction

  // Monitor: protocol timing, hold checks, and scoreboard pops.
  int busy = 0;
  int age = 0;
  int cnt_m = 0;
  bit pv = 0;
  bit phs = 0;
  logic [W-1:0] pd;
  logic pe;

  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      chk("rst_reqReady", 32'(bus.reqReady), 32'(1));
      chk("rst_rspValid", 32'(bus.rspValid), 32'(0));
      chk("rst_rspData", 32'(bus.rspData), 32'(0));
      chk("rst_rspErr", 32'(bus.rspErr), 32'(0));
      chk("rst_opCount", 32'(opCount), 32'(0));
      chk("rst_cmd", 32'({aIn, bIn, doAnd, doOr}), 32'(0));
      q.delete();
      busy = 0;
      cnt_m = 0;
      pv = 0;
      phs = 0;
    end else begin
      chk("reqReady", 32'(bus.reqReady), 32'(busy == 0));
      chk("opCount", 32'(opCount), 32'(cnt_m));
      chk("excl", 32'(doAnd & doOr), 32'(0));
      if (busy == 0) begin
        chk("idle_cmd", 32'({aIn, bIn, doAnd, doOr}), 32'(0));
        chk("idle_rsp", 32'(bus.rspValid), 32'(0));
      end else begin
        age++;
        if (age <= S) begin
          if (q.size() > 0)
            chk("cmd", 32'({aIn, bIn, doAnd, doOr}),
                32'({q[0].a, q[0].b, q[0].op, !q[0].op}));
          chk("early_rsp", 32'(bus.rspValid), 32'(0));
        end else begin
          chk("rsp_valid", 32'(bus.rspValid), 32'(1));
          chk("rsp_cmd0", 32'({aIn, bIn, doAnd, doOr}), 32'(0));
          if (pv && !phs)
            chk("rsp_hold", 32'({bus.rspData, bus.rspErr}), 32'({pd, pe}));
        end
      end
      phs = bus.rspValid && bus.rspReady;
      if (busy != 0 && phs) begin
        if (q.size() == 0) begin
          chk("sb_empty", 32'(0), 32'(1));
        end else begin
          e = q.pop_front();
          chk("rspData", 32'(bus.rspData), 32'(e.d));
          chk("rspErr", 32'(bus.rspErr), 32'(e.e));
        end
        cnt_m = (cnt_m + 1) % (1 << CW);
        busy = 0;
      end
      if (bus.reqValid && bus.reqReady && busy == 0) begin
        busy = 1;
        age = 0;
      end
      pv = bus.rspValid;
      pd = bus.rspData;
      pe = bus.rspErr;
    end
  end

  task automatic wait_acc(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.reqReady) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("acc_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rspValid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'(0), 32'(1));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic op, input bit fi, input bit fo);
    bit ok;
    f_isand = fi;
    f_out = fo;
    bus.reqA = a;
    bus.reqB = b;
    bus.reqOp = op;
    bus.reqValid = 1'b1;
    wait_acc(ok);
    if (ok) q.push_back(model(a, b, op, fi, fo));
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
  endtask

  task automatic take(input int stall);
    bit ok;
    wait_rsp(ok);
    if (ok) begin
      repeat (stall) @(negedge clk);
      @(posedge clk);
      #1 bus.rspReady = 1'b1;
      @(posedge clk);
      #1 bus.rspReady = 1'b0;
    end
    f_isand = 1'b0;
    f_out = 1'b0;
  endtask

  initial begin
    bit ok;
    bus.reqValid = 1'b0;
    bus.reqA = '0;
    bus.reqB = '0;
    bus.reqOp = 1'b0;
    bus.rspReady = 1'b0;
    f_isand = 1'b0;
    f_out = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    send(4'b1100, 4'b1010, 1'b1, 0, 0);
    take(0);
    send(4'b1100, 4'b1010, 1'b0, 0, 0);
    take(0);

    // Back-to-back with request held and response always ready.
    bus.rspReady = 1'b1;
    bus.reqA = 4'b0110;
    bus.reqB = 4'b0011;
    bus.reqOp = 1'b1;
    bus.reqValid = 1'b1;
    wait_acc(ok);
    if (ok) q.push_back(model(4'b0110, 4'b0011, 1'b1, 0, 0));
    @(posedge clk);
    #1;
    wait_rsp(ok);
    @(negedge clk);
    chk("b2b_gap", 32'(bus.reqReady), 32'(1));
    q.push_back(model(4'b0110, 4'b0011, 1'b1, 0, 0));
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    wait_rsp(ok);
    @(posedge clk);
    #1 bus.rspReady = 1'b0;

    send(4'b1001, 4'b0101, 1'b1, 0, 0);
    take(5);
    send(4'hF, 4'hF, 1'b1, 1, 0);
    take(1);
    send(4'h3, 4'h4, 1'b0, 0, 1);
    take(0);

    // Abort in the second settle cycle.
    send(4'hA, 4'h6, 1'b1, 0, 0);
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("abort_cmd", 32'({aIn, bIn, doAnd, doOr}), 32'(0));
    chk("abort_ready", 32'(bus.reqReady), 32'(1));
    chk("abort_rsp", 32'(bus.rspValid), 32'(0));
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (S + 2) begin
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 5; i++) begin
      send(4'(i), 4'(i + 3), 1'(i), 0, 0);
      take(0);
    end

    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
      take(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
